// File: rtl/ap_mult_pkg.sv
// Shared types and helpers for the 12b approximate multiplier accumulator.
// Holds the product width, FSM states and saturation bounds.
package ap_mult_pkg;

    localparam int PROD_W = 24;

    typedef enum logic {
        S_ACC  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    function automatic logic signed [63:0] sat_max(int aw);
        return (64'sd1 <<< (aw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(int aw);
        return -(64'sd1 <<< (aw - 1));
    endfunction

endpackage

// File: rtl/ap_sat_add.sv
// Combinational signed adder with optional clamp on overflow.
// The sum is formed one bit wider so overflow is a sign-bit mismatch.
module ap_sat_add
    import ap_mult_pkg::*;
#(
    parameter int AW  = 32,
    parameter bit SAT = 1'b1
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          ovf
);

    localparam logic [AW-1:0] MAX_V = AW'(sat_max(AW));
    localparam logic [AW-1:0] MIN_V = AW'(sat_min(AW));

    logic [AW:0] wide;

    assign wide = {a[AW-1], a} + {b[AW-1], b};
    assign ovf  = wide[AW] ^ wide[AW-1];

    always_comb begin
        sum = wide[AW-1:0];
        if (SAT && ovf) begin
            sum = wide[AW] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/ap_mult_acc_12b.sv
// Registers signed products from the approximate multiplier and sums them
// into one dot-product result per group (closed by last or by MAX_TERMS).
module ap_mult_acc_12b
    import ap_mult_pkg::*;
#(
    parameter int PW        = PROD_W,
    parameter int AW        = 32,
    parameter int MAX_TERMS = 256,
    parameter bit SAT       = 1'b1,
    localparam int CW       = $clog2(MAX_TERMS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          prod_vld,
    output logic          prod_rdy,
    input  logic [PW-1:0] prod,
    input  logic          prod_last,
    output logic          acc_vld,
    input  logic          acc_rdy,
    output logic [AW-1:0] acc_data,
    output logic [CW-1:0] acc_cnt,
    output logic          acc_ovf
);

    state_t        state;
    logic          s1_full;
    logic [PW-1:0] s1_prod;
    logic          s1_last;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic          s1_adv;
    logic          in_hs;
    logic          restart;
    logic [AW-1:0] add_a;
    logic [AW-1:0] add_b;
    logic [AW-1:0] add_sum;
    logic          add_ovf;
    logic [CW-1:0] cnt_nxt;
    logic          ovf_nxt;
    logic          close;

    assign s1_adv   = s1_full & ((state == S_ACC) | acc_rdy);
    assign prod_rdy = !rst & !clr & (!s1_full | s1_adv);
    assign in_hs    = prod_vld & prod_rdy;

    // Advancing while a result is handed off starts the next group fresh.
    assign restart = (state == S_DONE);
    assign add_a   = restart ? '0 : acc;
    assign add_b   = AW'(signed'(s1_prod));
    assign cnt_nxt = (restart ? '0 : cnt) + CW'(1);
    assign ovf_nxt = (restart ? 1'b0 : ovf) | add_ovf;
    assign close   = s1_last | (cnt_nxt == CW'(MAX_TERMS));

    ap_sat_add #(
        .AW  (AW),
        .SAT (SAT)
    ) u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_ACC;
            s1_full <= 1'b0;
            s1_prod <= '0;
            s1_last <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
        end else if (clr) begin
            state   <= S_ACC;
            s1_full <= 1'b0;
            s1_prod <= '0;
            s1_last <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
        end else begin
            if (in_hs) begin
                s1_full <= 1'b1;
                s1_prod <= prod;
                s1_last <= prod_last;
            end else if (s1_adv) begin
                s1_full <= 1'b0;
            end

            if (s1_adv) begin
                acc   <= add_sum;
                cnt   <= cnt_nxt;
                ovf   <= ovf_nxt;
                state <= close ? S_DONE : S_ACC;
            end else if (restart && acc_rdy) begin
                acc   <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
                state <= S_ACC;
            end
        end
    end

    assign acc_vld  = (state == S_DONE);
    assign acc_data = acc;
    assign acc_cnt  = cnt;
    assign acc_ovf  = ovf;

endmodule
